// File: rtl/axi_cfg_regbank_if.sv
// rtl/axi_cfg_regbank_if.sv - AXI4-Lite slave bus bundle for axi_cfg_regbank
interface axi_cfg_regbank_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_cfg_regbank.sv
// rtl/axi_cfg_regbank.sv - AXI4-Lite config register bank with sampled network/aux inputs
// Net-change status, irq_enable and irq exist only when AXI_CFG_IRQ_EN is defined.
module axi_cfg_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 9,
  parameter int C_NUM_AUX          = 4,
  parameter int C_AUX_WIDTH        = 12,
  parameter int C_NET_WIDTH        = 2
) (
  input  logic                             S_AXI_ACLK,
  input  logic                             S_AXI_ARESETN,
  axi_cfg_regbank_if.slave                 s_axi,
  input  logic [C_NET_WIDTH-1:0]           network_output,
  input  logic [C_NUM_AUX*C_AUX_WIDTH-1:0] measured_aux,
  output logic [1:0]                       char_select,
  output logic [15:0]                      direct_ctrl,
  output logic [31:0]                      debug,
  output logic                             irq
);

  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int SW   = DW / 8;
  localparam int AUXW = C_NUM_AUX * C_AUX_WIDTH;

`ifdef AXI_CFG_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  localparam logic [5:0] W_CHAR  = 6'h00;
  localparam logic [5:0] W_NET   = 6'h01;
  localparam logic [5:0] W_DCTL  = 6'h02;
  localparam logic [5:0] W_DBG   = 6'h03;
  localparam logic [5:0] W_STAT  = 6'h04;
  localparam logic [5:0] W_IRQEN = 6'h05;
  localparam logic [5:0] W_AUX0  = 6'h08;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [DW-1:0] strb_merge(input logic [DW-1:0] old_val,
                                               input logic [DW-1:0] new_val,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_val;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr;
  logic [C_S_AXI_ADDR_WIDTH-1:0] araddr;
  logic [5:0]  wr_word, rd_word;
  logic        wr_en, rd_en, wr_ok, rd_ok;
  logic        net_set, net_clr;
  logic [DW-1:0] wr_char, wr_dctl, wr_dbg, wr_irqen, rd_val;

  logic [1:0]             char_sel_q, char_sel_d;
  logic [15:0]            dctl_q, dctl_d;
  logic [DW-1:0]          dbg_q, dbg_d;
  logic [C_NET_WIDTH-1:0] net_samp_q, net_samp_d;
  logic [AUXW-1:0]        aux_samp_q, aux_samp_d;
  logic                   samp_valid_q, samp_valid_d;
  logic                   net_chg_q, net_chg_d;
  logic                   irq_en_q, irq_en_d;
  logic                   irq_q, irq_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   rvalid_q, rvalid_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [DW-1:0]          rdata_q, rdata_d;

  logic unused_bits;

  assign awaddr = s_axi.AWADDR;
  assign araddr = s_axi.ARADDR;
  assign unused_bits = ^{awaddr, araddr, wr_char, wr_dctl, wr_irqen};

  // Ready strobes are gated by reset so nothing is accepted while it is held.
  always_comb begin
    wr_en   = S_AXI_ARESETN && s_axi.AWVALID && s_axi.WVALID && !bvalid_q;
    wr_word = awaddr[7:2];
    wr_ok   = (wr_word == W_CHAR) || (wr_word == W_DCTL) || (wr_word == W_DBG) ||
              (IRQ_EN && ((wr_word == W_STAT) || (wr_word == W_IRQEN)));

    wr_char  = strb_merge(DW'(char_sel_q), s_axi.WDATA, s_axi.WSTRB);
    wr_dctl  = strb_merge(DW'(dctl_q), s_axi.WDATA, s_axi.WSTRB);
    wr_dbg   = strb_merge(dbg_q, s_axi.WDATA, s_axi.WSTRB);
    wr_irqen = strb_merge(DW'(irq_en_q), s_axi.WDATA, s_axi.WSTRB);

    char_sel_d = char_sel_q;
    dctl_d     = dctl_q;
    dbg_d      = dbg_q;
    irq_en_d   = irq_en_q;
    if (wr_en && wr_word == W_CHAR) char_sel_d = wr_char[1:0];
    if (wr_en && wr_word == W_DCTL) dctl_d = wr_dctl[15:0];
    if (wr_en && wr_word == W_DBG)  dbg_d = wr_dbg;
    if (IRQ_EN && wr_en && wr_word == W_IRQEN) irq_en_d = wr_irqen[0];
    if (!IRQ_EN) irq_en_d = 1'b0;

    net_samp_d   = network_output;
    aux_samp_d   = measured_aux;
    samp_valid_d = 1'b1;

    // A fresh change wins over a simultaneous write-one-to-clear.
    net_set   = IRQ_EN && samp_valid_q && (network_output != net_samp_q);
    net_clr   = IRQ_EN && wr_en && (wr_word == W_STAT) && s_axi.WSTRB[0] && s_axi.WDATA[0];
    net_chg_d = (net_chg_q && !net_clr) || net_set;
    irq_d     = net_chg_q && irq_en_q;

    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (wr_en) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && s_axi.BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  always_comb begin
    rd_en   = S_AXI_ARESETN && s_axi.ARVALID && !rvalid_q;
    rd_word = araddr[7:2];
    rd_val  = '0;
    rd_ok   = 1'b1;
    case (rd_word)
      W_CHAR: rd_val = DW'(char_sel_q);
      W_NET:  rd_val = DW'(net_samp_q);
      W_DCTL: rd_val = DW'(dctl_q);
      W_DBG:  rd_val = dbg_q;
      W_STAT: begin
        rd_ok  = IRQ_EN;
        rd_val = IRQ_EN ? DW'(net_chg_q) : '0;
      end
      W_IRQEN: begin
        rd_ok  = IRQ_EN;
        rd_val = IRQ_EN ? DW'(irq_en_q) : '0;
      end
      default: begin
        rd_ok = 1'b0;
        for (int i = 0; i < C_NUM_AUX; i++) begin
          if (rd_word == W_AUX0 + 6'(i)) begin
            rd_ok  = 1'b1;
            rd_val = DW'(aux_samp_q[i*C_AUX_WIDTH +: C_AUX_WIDTH]);
          end
        end
      end
    endcase

    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (rd_en) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
      rdata_d  = rd_val;
    end else if (rvalid_q && s_axi.RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      char_sel_q   <= '0;
      dctl_q       <= '0;
      dbg_q        <= '0;
      net_samp_q   <= '0;
      aux_samp_q   <= '0;
      samp_valid_q <= 1'b0;
      net_chg_q    <= 1'b0;
      irq_en_q     <= 1'b0;
      irq_q        <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= '0;
      rvalid_q     <= 1'b0;
      rresp_q      <= '0;
      rdata_q      <= '0;
    end else begin
      char_sel_q   <= char_sel_d;
      dctl_q       <= dctl_d;
      dbg_q        <= dbg_d;
      net_samp_q   <= net_samp_d;
      aux_samp_q   <= aux_samp_d;
      samp_valid_q <= samp_valid_d;
      net_chg_q    <= net_chg_d;
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      rvalid_q     <= rvalid_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
    end
  end

  assign s_axi.AWREADY = wr_en;
  assign s_axi.WREADY  = wr_en;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = bresp_q;
  assign s_axi.ARREADY = rd_en;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RRESP   = rresp_q;
  assign s_axi.RDATA   = rdata_q;

  assign char_select = char_sel_q;
  assign direct_ctrl = dctl_q;
  assign debug       = dbg_q;
  assign irq         = IRQ_EN ? irq_q : 1'b0;

endmodule

// File: tb/tb_axi_cfg_regbank.sv
// tb/tb_axi_cfg_regbank.sv - directed self-checking bench for axi_cfg_regbank
module tb_axi_cfg_regbank;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  net;
  logic [47:0] aux;
  logic [1:0]  char_select;
  logic [15:0] direct_ctrl;
  logic [31:0] debug;
  logic        irq;
  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_cfg_regbank_if #(.ADDR_W(9), .DATA_W(32)) bus ();

  axi_cfg_regbank #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(9),
    .C_NUM_AUX(4), .C_AUX_WIDTH(12), .C_NET_WIDTH(2)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (bus.slave),
    .network_output(net),
    .measured_aux  (aux),
    .char_select   (char_select),
    .direct_ctrl   (direct_ctrl),
    .debug         (debug),
    .irq           (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr_chk(input string tag, input logic [8:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] er);
    bit acc = 1'b0;
    bus.AWADDR = a; bus.WDATA = d; bus.WSTRB = s;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    for (int i = 0; i < 16 && !acc; i++) begin
      @(negedge clk);
      acc = bus.AWREADY && bus.WREADY;
      @(posedge clk); #1;
    end
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    chk({tag, "_accept"}, 32'(acc), 32'd1);
    chk({tag, "_bvalid"}, 32'(bus.BVALID), 32'd1);
    chk({tag, "_bresp"}, 32'(bus.BRESP), 32'(er));
    bus.BREADY = 1'b1;
    @(posedge clk); #1;
    bus.BREADY = 1'b0;
    chk({tag, "_bdone"}, 32'(bus.BVALID), 32'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [8:0] a, input int hold,
                        input logic [31:0] exp, input logic [1:0] er);
    bit acc = 1'b0;
    bus.ARADDR = a; bus.ARVALID = 1'b1;
    for (int i = 0; i < 16 && !acc; i++) begin
      @(negedge clk);
      acc = bus.ARREADY;
      @(posedge clk); #1;
    end
    bus.ARVALID = 1'b0;
    chk({tag, "_accept"}, 32'(acc), 32'd1);
    for (int k = 0; k < hold; k++) begin
      chk({tag, "_hold_rvalid"}, 32'(bus.RVALID), 32'd1);
      chk({tag, "_hold_rdata"}, bus.RDATA, exp);
      @(posedge clk); #1;
    end
    chk({tag, "_rvalid"}, 32'(bus.RVALID), 32'd1);
    chk({tag, "_rdata"}, bus.RDATA, exp);
    chk({tag, "_rresp"}, 32'(bus.RRESP), 32'(er));
    bus.RREADY = 1'b1;
    @(posedge clk); #1;
    bus.RREADY = 1'b0;
    chk({tag, "_rdone"}, 32'(bus.RVALID), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    net = 2'b01;
    aux = '0;
    bus.AWADDR = '0; bus.WDATA = '0; bus.WSTRB = '0; bus.ARADDR = '0;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_readies", 32'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 32'd0);
    chk("rst_valids", 32'({bus.BVALID, bus.RVALID, irq}), 32'd0);
    chk("rst_resps", 32'({bus.RRESP, bus.BRESP}), 32'd0);
    chk("rst_rdata", bus.RDATA, 32'd0);
    chk("rst_regs", {char_select, direct_ctrl, 14'd0} | debug, 32'd0);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    wr_chk("dctl_strb0", 9'h008, 32'h0000ABCD, 4'b0001, 2'b00);
    chk("dctl_strb0_val", 32'(direct_ctrl), 32'h000000CD);
    wr_chk("dctl_full", 9'h008, 32'hFFFF1234, 4'b1111, 2'b00);
    chk("dctl_full_val", 32'(direct_ctrl), 32'h00001234);
    rd_chk("rd_dctl", 9'h008, 0, 32'h00001234, 2'b00);
    wr_chk("dbg_hi", 9'h00C, 32'hDEADBEEF, 4'b1100, 2'b00);
    chk("dbg_hi_val", debug, 32'hDEAD0000);
    wr_chk("char", 9'h000, 32'hFFFFFFFF, 4'b0001, 2'b00);
    chk("char_val", 32'(char_select), 32'd3);
    rd_chk("rd_char_lowbits", 9'h003, 0, 32'd3, 2'b00);
    rd_chk("rd_net", 9'h004, 0, 32'd1, 2'b00);

    aux = {12'hFFF, 12'h000, 12'h000, 12'hABC};
    repeat (2) @(posedge clk);
    #1;
    rd_chk("rd_aux0", 9'h020, 0, 32'h00000ABC, 2'b00);
    rd_chk("rd_aux3_stall", 9'h02C, 5, 32'h00000FFF, 2'b00);

    wr_chk("wr_ro_net", 9'h004, 32'hFFFFFFFF, 4'b1111, 2'b10);
    rd_chk("rd_net_after", 9'h004, 0, 32'd1, 2'b00);
    rd_chk("rd_unmapped", 9'h040, 0, 32'd0, 2'b10);
    wr_chk("wr_unmapped", 9'h01C, 32'h12345678, 4'b1111, 2'b10);
    chk("dbg_untouched", debug, 32'hDEAD0000);

    // AWVALID leads WVALID by three cycles
    bus.AWADDR = 9'h00C; bus.WDATA = 32'h5A5A5A5A; bus.WSTRB = 4'b1111;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("aw_early_ready", 32'({bus.AWREADY, bus.WREADY}), 32'd0);
    end
    bus.WVALID = 1'b1;
    #1;
    chk("aw_w_ready_pulse", 32'({bus.AWREADY, bus.WREADY}), 32'd3);
    @(posedge clk); #1;
    chk("aw_w_ready_once", 32'({bus.AWREADY, bus.WREADY}), 32'd0);
    chk("aw_w_bvalid", 32'(bus.BVALID), 32'd1);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b1;
    @(posedge clk); #1;
    bus.BREADY = 1'b0;
    chk("aw_w_debug", debug, 32'h5A5A5A5A);

    // simultaneous read and write of debug
    bus.AWADDR = 9'h00C; bus.WDATA = 32'h11111111; bus.WSTRB = 4'b1111;
    bus.ARADDR = 9'h00C;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
    @(negedge clk);
    chk("rw_same_ready", 32'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 32'd7);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    chk("rw_same_rdata", bus.RDATA, 32'h5A5A5A5A);
    chk("rw_same_debug", debug, 32'h11111111);
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    @(posedge clk); #1;
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;

`ifdef AXI_CFG_IRQ_EN
    wr_chk("w1c_init", 9'h010, 32'd1, 4'b0001, 2'b00);
    wr_chk("irqen_set", 9'h014, 32'd1, 4'b0001, 2'b00);
    rd_chk("rd_irqen", 9'h014, 0, 32'd1, 2'b00);
    chk("irq_idle", 32'(irq), 32'd0);
    net = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    chk("irq_on_change", 32'(irq), 32'd1);
    rd_chk("rd_status_set", 9'h010, 0, 32'd1, 2'b00);
    wr_chk("w1c_clear", 9'h010, 32'd1, 4'b0001, 2'b00);
    chk("irq_cleared", 32'(irq), 32'd0);
    rd_chk("rd_status_clr", 9'h010, 0, 32'd0, 2'b00);
    bus.AWADDR = 9'h010; bus.WDATA = 32'd1; bus.WSTRB = 4'b0001;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    @(negedge clk);
    net = 2'b01;
    @(posedge clk); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b1;
    @(posedge clk); #1;
    bus.BREADY = 1'b0;
    chk("irq_set_wins", 32'(irq), 32'd1);
    rd_chk("rd_status_set_wins", 9'h010, 0, 32'd1, 2'b00);
`else
    wr_chk("wr_status_unmapped", 9'h010, 32'd1, 4'b0001, 2'b10);
    rd_chk("rd_irqen_unmapped", 9'h014, 0, 32'd0, 2'b10);
    net = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    chk("irq_tied_low", 32'(irq), 32'd0);
`endif

    // reset while a write response is pending
    bus.AWADDR = 9'h00C; bus.WDATA = 32'hCAFEF00D; bus.WSTRB = 4'b1111;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    chk("rst_mid_bvalid_pre", 32'(bus.BVALID), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_bvalid", 32'(bus.BVALID), 32'd0);
    chk("rst_mid_debug", debug, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_chk("post_rst_char", 9'h000, 0, 32'd0, 2'b00);
    rd_chk("post_rst_dctl", 9'h008, 0, 32'd0, 2'b00);
    rd_chk("post_rst_dbg", 9'h00C, 0, 32'd0, 2'b00);
`ifdef AXI_CFG_IRQ_EN
    rd_chk("post_rst_irqen", 9'h014, 0, 32'd0, 2'b00);
    chk("post_rst_irq", 32'(irq), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_cfg_regbank.md
AXI_CFG_REGBANK -- requirements
Module: axi_cfg_regbank

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 9, AXI address width (min 8).
REQ-003 SHALL have parameter C_NUM_AUX, default 4, measured-channel count (1..16).
REQ-004 SHALL have parameter C_AUX_WIDTH, default 12, bits per measured channel (1..32).
REQ-005 SHALL have parameter C_NET_WIDTH, default 2, network_output width (1..32).
REQ-006 SHALL have port S_AXI_ACLK input 1, the single clock; all logic is clocked on its rising edge.
REQ-007 SHALL have port S_AXI_ARESETN input 1, asynchronous active-low reset.
REQ-008 SHALL have AXI4-Lite slave ports AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY (S_AXI_ prefix, standard directions/widths).
REQ-009 SHALL have port network_output input C_NET_WIDTH, the network result to be read back.
REQ-010 SHALL have port measured_aux input C_NUM_AUX*C_AUX_WIDTH, packed channels with channel i at bits [i*C_AUX_WIDTH +: C_AUX_WIDTH].
REQ-011 SHALL have outputs char_select 2, direct_ctrl 16, debug 32 and irq 1, driven directly from registers.

Function
REQ-012 SHALL decode the word address ADDR[7:2]; ADDR[1:0] ignored.
REQ-013 SHALL provide this map: 0x00 char_select RW[1:0]; 0x04 network_output RO; 0x08 direct_ctrl RW[15:0]; 0x0C debug RW[31:0]; 0x10 status W1C (bit0 net_changed); 0x14 irq_enable RW[0]; 0x20+4*i aux[i] RO, zero-extended, for i < C_NUM_AUX.
REQ-014 SHALL return RRESP/BRESP = 2'b10 (SLVERR) for unmapped addresses and for writes to RO registers, with no state change; reads of unmapped addresses return 0.
REQ-015 SHALL accept a write only when AWVALID and WVALID are both high and BVALID is low, asserting AWREADY and WREADY together for exactly that one cycle.
REQ-016 SHALL apply written data in the acceptance cycle and assert BVALID on the next cycle, holding BVALID/BRESP stable until BREADY.
REQ-017 SHALL apply WSTRB per byte; bytes whose strobe is low are unchanged; bits above a register's width are ignored.
REQ-018 SHALL accept a read when ARVALID is high and RVALID is low (ARREADY high for that one cycle), registering RDATA/RRESP and asserting RVALID on the next cycle, holding both stable until RREADY.
REQ-019 SHALL run the read and write channels independently; a read and a write to the same register in the same cycle return the pre-write value.
REQ-020 SHALL sample network_output and each aux channel into registers every cycle (read value at most 1 cycle stale).
REQ-021 SHALL set status.net_changed when the sampled network_output differs from its previous sample; if a set and a W1C clear occur in the same cycle, the set wins.
REQ-022 SHALL drive irq = status.net_changed AND irq_enable, registered.

Reset
REQ-023 SHALL, while S_AXI_ARESETN is low, clear all registers, samples and status, and drive AWREADY/WREADY/ARREADY/BVALID/RVALID/irq to 0, RDATA to 0 and RRESP/BRESP to 00.
REQ-024 SHALL abandon any in-flight transaction on reset, with no partial write.
REQ-025 SHALL not report net_changed for the first sample after reset.

Configuration
REQ-026 SHALL, when AXI_CFG_IRQ_EN is defined, implement status, irq_enable and irq per REQ-021/REQ-022.
REQ-027 SHALL, when AXI_CFG_IRQ_EN is undefined, treat 0x10 and 0x14 as unmapped (SLVERR) and tie irq to 0.

Verification
REQ-028 Write 0x0000ABCD to 0x08 with WSTRB=4'b0001 after reset -> direct_ctrl=0x00CD, BRESP=00, BVALID one cycle after acceptance.
REQ-029 Drive measured_aux ch3=0xFFF, hold RREADY low 5 cycles, read 0x2C -> RDATA=0x00000FFF, RVALID held stable for all 5 cycles.
REQ-030 Write to 0x04, then read 0x40 (C_NUM_AUX=4) -> both SLVERR; network_output register unchanged; read data 0.
REQ-031 With IRQ_EN defined and irq_enable=1, change network_output 01->10 -> irq=1 within 2 cycles; W1C 0x1 to 0x10 -> irq=0; a change in the same cycle as the clear keeps irq=1.
REQ-032 Assert AWVALID 3 cycles before WVALID -> AWREADY stays low until WVALID is high, then AWREADY and WREADY pulse together once.
REQ-033 Drop S_AXI_ARESETN while BVALID is high -> BVALID=0 immediately and all RW registers read 0 after reset release.
